// File: rtl/rv32cpu_type.sv
// ---------------------------------------------------------------------------
// rv32cpu_type
// Shared CPU types. cdb_entry_t is the payload carried on the common data
// bus: a valid flag, the ROB tag of the producing instruction and the result
// value. ptr_width() sizes round-robin pointers so that a single-requester
// configuration still gets a 1-bit pointer.
// ---------------------------------------------------------------------------
package rv32cpu_type;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } cdb_entry_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// ---------------------------------------------------------------------------
// cdb_rr_picker
// Purely combinational round-robin picker for the CDB scheduler. Scans the
// request vector starting at rr_ptr (wrapping modulo FUNC_UNITS) and grants
// the first CDB_WIDTH valid requesters it meets. The k-th grant is steered
// to lane k.
//
// Ports
//   valid      in   FUNC_UNITS    request vector (one bit per FU)
//   rr_ptr     in   PTR_W         first FU to consider this cycle
//   grant      out  FUNC_UNITS    one-hot-per-winner grant vector
//   lane_idx   out  PTR_W x LANES FU index feeding each lane
//   lane_valid out  CDB_WIDTH     lane carries a granted request
//   next_ptr   out  PTR_W         one past the last granted FU, or rr_ptr
//                                 when nothing was granted
// ---------------------------------------------------------------------------
module cdb_rr_picker
    import rv32cpu_type::*;
#(
    parameter  int FUNC_UNITS = 4,
    parameter  int CDB_WIDTH  = 2,
    localparam int PTR_W      = ptr_width(FUNC_UNITS),
    localparam int CNT_W      = $clog2(CDB_WIDTH + 1)
) (
    input  logic [FUNC_UNITS-1:0] valid,
    input  logic [PTR_W-1:0]      rr_ptr,
    output logic [FUNC_UNITS-1:0] grant,
    output logic [PTR_W-1:0]      lane_idx [CDB_WIDTH],
    output logic [CDB_WIDTH-1:0]  lane_valid,
    output logic [PTR_W-1:0]      next_ptr
);

    logic [CNT_W-1:0] taken;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last;
    int               sum;

    // Walk the FUs in priority order. 'taken' counts grants handed out so
    // far and doubles as the lane number for the next winner; lane indices
    // are only ever written through constant loop indices.
    always_comb begin
        grant      = '0;
        lane_valid = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            lane_idx[k] = '0;
        end
        taken    = '0;
        idx      = '0;
        last     = '0;
        sum      = 0;
        next_ptr = rr_ptr;

        for (int j = 0; j < FUNC_UNITS; j++) begin
            sum = int'(rr_ptr) + j;
            if (sum >= FUNC_UNITS) begin
                sum = sum - FUNC_UNITS;
            end
            idx = PTR_W'(sum);
            if (valid[idx] && (int'(taken) < CDB_WIDTH)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (int'(taken) == k) begin
                        lane_idx[k]   = idx;
                        lane_valid[k] = 1'b1;
                    end
                end
                last  = idx;
                taken = taken + 1'b1;
            end
        end

        // Resume just after the last winner so the next cycle starts with
        // the FU that was skipped longest.
        if (taken != '0) begin
            next_ptr = (int'(last) == FUNC_UNITS - 1) ? '0 : last + 1'b1;
        end
    end

endmodule

// File: rtl/cdb_scheduler.sv
// ---------------------------------------------------------------------------
// cdb_scheduler
// Shares CDB_WIDTH common-data-bus broadcast lanes among FUNC_UNITS
// functional units. Each cycle up to CDB_WIDTH valid results are granted in
// round-robin order, acknowledged combinationally, and registered onto the
// CDB so they broadcast one cycle later.
//
// Ports
//   clk      in   1                       clock, all state on posedge
//   rst_n    in   1                       asynchronous active-low reset
//   fu_req   in   cdb_entry_t[FUNC_UNITS] per-FU result, .valid = request
//   fu_ack   out  FUNC_UNITS              combinational take strobe per FU
//   cdb_out  out  cdb_entry_t[CDB_WIDTH]  registered broadcast lanes
//   flush    in   1                       only with CDB_FLUSH_EN: squash
//
// Build options
//   CDB_FLUSH_EN  adds the flush port. While flush is high no request is
//                 acked, the next cdb_out is all invalid and rr_ptr holds.
// ---------------------------------------------------------------------------
module cdb_scheduler
    import rv32cpu_type::*;
#(
    parameter int FUNC_UNITS = 4,
    parameter int CDB_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  cdb_entry_t            fu_req  [FUNC_UNITS],
    output logic [FUNC_UNITS-1:0] fu_ack,
    output cdb_entry_t            cdb_out [CDB_WIDTH]
`ifdef CDB_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    localparam int PTR_W = ptr_width(FUNC_UNITS);

    // More lanes than requesters, or no lanes at all, is a configuration
    // error rather than something to quietly clamp.
    generate
        if (CDB_WIDTH < 1 || CDB_WIDTH > FUNC_UNITS) begin : g_bad_cfg
            $error("cdb_scheduler: CDB_WIDTH must lie in 1..FUNC_UNITS");
        end
    endgenerate

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [PTR_W-1:0]      pick_next_ptr;
    logic [FUNC_UNITS-1:0] req_valid;
    logic [FUNC_UNITS-1:0] grant;
    logic [PTR_W-1:0]      lane_idx   [CDB_WIDTH];
    logic [CDB_WIDTH-1:0]  lane_valid;
    cdb_entry_t            lane_next  [CDB_WIDTH];
    logic                  flush_active;

`ifdef CDB_FLUSH_EN
    assign flush_active = flush;
`else
    assign flush_active = 1'b0;
`endif

    // Collect the request bits out of the entry structs for the picker.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < FUNC_UNITS; i++) begin
            req_valid[i] = fu_req[i].valid;
        end
    end

    cdb_rr_picker #(
        .FUNC_UNITS (FUNC_UNITS),
        .CDB_WIDTH  (CDB_WIDTH)
    ) u_picker (
        .valid      (req_valid),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .next_ptr   (pick_next_ptr)
    );

    // Flush gating and the lane mux. A flushed cycle acks nothing, loads
    // empty lanes and leaves the pointer where it was, so the squashed
    // requesters keep their turn once the flush drops.
    always_comb begin
        fu_ack   = grant & ~{FUNC_UNITS{flush_active}};
        ptr_next = flush_active ? rr_ptr : pick_next_ptr;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            lane_next[k] = '0;
            if (lane_valid[k] && !flush_active) begin
                lane_next[k] = fu_req[lane_idx[k]];
            end
        end
    end

    // Pointer and broadcast registers. Reset drops whatever was in flight;
    // un-acked producers simply present their entries again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_out[k] <= '0;
            end
        end else begin
            rr_ptr <= ptr_next;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_out[k] <= lane_next[k];
            end
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cdb_scheduler
// Scoreboard bench for cdb_scheduler. Directed vectors run on a 4-FU/2-lane
// instance; a 3-FU/3-lane instance acts as a pure pipeline register and is
// fed random request masks. Drivers push the expected broadcast lanes, and
// one monitor per instance pops and compares whenever a lane is valid.
// ---------------------------------------------------------------------------
module tb_cdb_scheduler;
    import rv32cpu_type::*;

    typedef cdb_entry_t [1:0] lanes4_t;
    typedef cdb_entry_t [2:0] lanes3_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    cdb_entry_t req4 [4];
    logic [3:0] ack4;
    cdb_entry_t out4 [2];
    cdb_entry_t req3 [3];
    logic [2:0] ack3;
    cdb_entry_t out3 [3];

    lanes4_t sb4 [$];
    lanes3_t sb3 [$];
    int      errors = 0;
    int      checks = 0;
    int      fuSeq [4];

    cdb_scheduler #(.FUNC_UNITS(4), .CDB_WIDTH(2)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .fu_req  (req4),
        .fu_ack  (ack4),
        .cdb_out (out4)
`ifdef CDB_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    cdb_scheduler #(.FUNC_UNITS(3), .CDB_WIDTH(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .fu_req  (req3),
        .fu_ack  (ack3),
        .cdb_out (out3)
`ifdef CDB_FLUSH_EN
        ,
        .flush   (1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cdb_entry_t mkEntry(input int fu, input int seq);
        cdb_entry_t e;
        e.valid = 1'b1;
        e.tag   = TAG_W'(fu + 8 * (seq % 8));
        e.data  = 32'hC0DE_0000 + 32'(seq * 16 + fu);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One directed cycle on the 4x2 instance. Starts just after a rising
    // edge, drives the mask, checks the ack, pushes the expected lanes,
    // crosses the next edge and checks the pointer. -1 marks an idle lane.
    task automatic applyStimulus(input string name, input logic [3:0] mask,
                                 input logic fl, input logic [3:0] expAck,
                                 input int expL0, input int expL1,
                                 input int expPtr);
        lanes4_t e;
        flush = fl;
        for (int i = 0; i < 4; i++) begin
            req4[i] = mask[i] ? mkEntry(i, fuSeq[i]) : '0;
        end
        #1;
        checkOutput({name, "_ack"}, 64'(ack4), 64'(expAck));
        e[0] = (expL0 >= 0) ? mkEntry(expL0, fuSeq[expL0 < 0 ? 0 : expL0]) : '0;
        e[1] = (expL1 >= 0) ? mkEntry(expL1, fuSeq[expL1 < 0 ? 0 : expL1]) : '0;
        if (expL0 >= 0) sb4.push_back(e);
        for (int i = 0; i < 4; i++) begin
            if (expAck[i]) fuSeq[i]++;
        end
        @(posedge clk);
        #1;
        checkOutput({name, "_ptr"}, 64'(dut4.rr_ptr), 64'(expPtr));
    endtask

    // Monitor for the 4x2 instance: any valid lane must match the oldest
    // expected broadcast.
    always @(negedge clk) begin
        lanes4_t e;
        if (out4[0].valid || out4[1].valid) begin
            if (sb4.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL cdb4_unexpected: got %h %h expected no broadcast",
                         out4[0], out4[1]);
            end else begin
                e = sb4.pop_front();
                checkOutput("cdb4_lane0", 64'(out4[0]), 64'(e[0]));
                checkOutput("cdb4_lane1", 64'(out4[1]), 64'(e[1]));
            end
        end
    end

    // Monitor for the 3x3 pipeline instance.
    always @(negedge clk) begin
        lanes3_t e;
        if (out3[0].valid || out3[1].valid || out3[2].valid) begin
            if (sb3.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL cdb3_unexpected: got %h %h %h expected no broadcast",
                         out3[0], out3[1], out3[2]);
            end else begin
                e = sb3.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checkOutput($sformatf("cdb3_lane%0d", k), 64'(out3[k]), 64'(e[k]));
                end
            end
        end
    end

    initial begin
        int      ptr3;
        int      k;
        int      f;
        int      lastF;
        logic [2:0] mask3;
        lanes3_t e3;

        rst_n = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req4[i]  = '0;
            fuSeq[i] = 1;
        end
        for (int i = 0; i < 3; i++) req3[i] = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_lane0", 64'(out4[0]), 64'd0);
        checkOutput("reset_lane1", 64'(out4[1]), 64'd0);
        checkOutput("reset_ptr", 64'(dut4.rr_ptr), 64'd0);
        rst_n = 1'b1;

        // Single request, then wrap with FU1 left waiting.
        applyStimulus("single_fu2", 4'b0100, 1'b0, 4'b0100, 2, -1, 3);
        applyStimulus("wrap_3_0", 4'b1011, 1'b0, 4'b1001, 3, 0, 1);
        applyStimulus("wait_fu1", 4'b0010, 1'b0, 4'b0010, 1, -1, 2);
        applyStimulus("idle", 4'b0000, 1'b0, 4'b0000, -1, -1, 2);
        checkOutput("idle_lanes", 64'({out4[1].valid, out4[0].valid}), 64'd0);

        // Mid-stream asynchronous reset with a lane in flight.
        applyStimulus("pre_reset", 4'b0100, 1'b0, 4'b0100, 2, -1, 3);
        checkOutput("pre_reset_valid", 64'(out4[0].valid), 64'd1);
        for (int i = 0; i < 4; i++) req4[i] = '0;
        rst_n = 1'b0;
        #1;
        sb4.delete();
        checkOutput("async_reset_lane0", 64'(out4[0]), 64'd0);
        checkOutput("async_reset_lane1", 64'(out4[1]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("post_reset_ptr", 64'(dut4.rr_ptr), 64'd0);

        // All four valid, held until acked; FU0/1 then re-request.
        applyStimulus("all_c0", 4'b1111, 1'b0, 4'b0011, 0, 1, 2);
        applyStimulus("all_c1", 4'b1111, 1'b0, 4'b1100, 2, 3, 0);
        applyStimulus("all_c2", 4'b0011, 1'b0, 4'b0011, 0, 1, 2);

        // Few valids are all granted at once, in scan order from rr_ptr.
        applyStimulus("two_wrap", 4'b1001, 1'b0, 4'b1001, 3, 0, 1);
        applyStimulus("skip_odd", 4'b0101, 1'b0, 4'b0101, 2, 0, 1);
        applyStimulus("three_of", 4'b1110, 1'b0, 4'b0110, 1, 2, 3);
        applyStimulus("from_3", 4'b0111, 1'b0, 4'b0011, 0, 1, 2);

`ifdef CDB_FLUSH_EN
        // Flush squashes the next broadcast and holds the pointer.
        applyStimulus("pre_flush", 4'b1111, 1'b0, 4'b1100, 2, 3, 0);
        applyStimulus("flush", 4'b0010, 1'b1, 4'b0000, -1, -1, 0);
        checkOutput("flush_squash", 64'({out4[1].valid, out4[0].valid}), 64'd0);
        applyStimulus("post_flush", 4'b0010, 1'b0, 4'b0010, 1, -1, 2);
`endif

        flush = 1'b0;
        for (int i = 0; i < 4; i++) req4[i] = '0;

        // Pure pipeline: FUNC_UNITS == CDB_WIDTH, every request granted.
        ptr3 = 0;
        for (int c = 0; c < 300; c++) begin
            mask3 = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                req3[i] = mask3[i] ? mkEntry(i, 1000 + c) : '0;
            end
            #1;
            checkOutput("pipe_ack", 64'(ack3), 64'(mask3));
            e3    = '0;
            k     = 0;
            lastF = 0;
            for (int j = 0; j < 3; j++) begin
                f = (ptr3 + j) % 3;
                if (mask3[f]) begin
                    e3[k] = mkEntry(f, 1000 + c);
                    k++;
                    lastF = f;
                end
            end
            if (k > 0) begin
                sb3.push_back(e3);
                ptr3 = (lastF + 1) % 3;
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) req3[i] = '0;

        // Drain and confirm nothing expected was left unbroadcast.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb4_drained", 64'(sb4.size()), 64'd0);
        checkOutput("sb3_drained", 64'(sb3.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
